// File: rtl/johnson_pkg.sv
// Shared definitions for the 4-bit Johnson counter: legal-code table,
// lock FSM states and the code-to-index lookup.
package johnson_pkg;

    localparam int JOHNSON_LEN = 8;

    // Entry i is the code emitted at phase i; bit [3] is the leading stage.
    localparam logic [3:0] JOHNSON_CODES [JOHNSON_LEN] = '{
        4'b0000, 4'b1000, 4'b1100, 4'b1110,
        4'b1111, 4'b0111, 4'b0011, 4'b0001
    };

    typedef enum logic {SEARCH, LOCKED} lock_state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } dec_t;

    function automatic dec_t code2idx(input logic [3:0] code);
        dec_t d;
        d = '0;
        for (int i = 0; i < JOHNSON_LEN; i++) begin
            if (code == JOHNSON_CODES[i]) begin
                d.legal = 1'b1;
                d.idx   = 3'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample stream into the Johnson decoder and its registered results.
interface johnson_decoder_if #(parameter int ERR_W = 8);
    logic [3:0]       code_in;
    logic             code_vld;
    logic [2:0]       phase;
    logic [7:0]       phase_oh;
    logic             code_err;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output code_in, code_vld,
        input  phase, phase_oh, code_err, seq_err, locked, err_cnt
    );

    modport slave (
        input  code_in, code_vld,
        output phase, phase_oh, code_err, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/johnson_code2idx.sv
// Combinational legality check and phase lookup for one Johnson code.
module johnson_code2idx
    import johnson_pkg::*;
(
    input  logic [3:0] code,
    output logic       legal,
    output logic [2:0] idx
);
    dec_t d;

    always_comb begin
        d     = code2idx(code);
        legal = d.legal;
        idx   = d.idx;
    end
endmodule

// File: rtl/johnson_decoder.sv
// Receive-side Johnson code checker: phase decode, code/step error pulses,
// saturating error count and a lock FSM gated on consecutive legal steps.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    johnson_decoder_if.slave  bus
);
    logic             legal;
    logic [2:0]       idx;

    lock_state_t      state, state_n;
    logic [3:0]       run, run_n;
    logic             ref_vld, ref_vld_n;
    logic [2:0]       ref_idx, ref_idx_n;
    logic [2:0]       phase, phase_n;
    logic [7:0]       phase_oh, phase_oh_n;
    logic             code_err, code_err_n;
    logic             seq_err, seq_err_n;
    logic             locked, locked_n;
    logic [ERR_W-1:0] err_cnt, err_cnt_n;

    johnson_code2idx u_dec (
        .code  (bus.code_in),
        .legal (legal),
        .idx   (idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            run      <= '0;
            ref_vld  <= 1'b0;
            ref_idx  <= '0;
            phase    <= '0;
            phase_oh <= 8'b0000_0001;
            code_err <= 1'b0;
            seq_err  <= 1'b0;
            locked   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            run      <= run_n;
            ref_vld  <= ref_vld_n;
            ref_idx  <= ref_idx_n;
            phase    <= phase_n;
            phase_oh <= phase_oh_n;
            code_err <= code_err_n;
            seq_err  <= seq_err_n;
            locked   <= locked_n;
            err_cnt  <= err_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        run_n      = run;
        ref_vld_n  = ref_vld;
        ref_idx_n  = ref_idx;
        phase_n    = phase;
        code_err_n = 1'b0;
        seq_err_n  = 1'b0;
        err_cnt_n  = err_cnt;

        if (bus.code_vld) begin
            if (!legal) begin
                code_err_n = 1'b1;
                ref_vld_n  = 1'b0;
                run_n      = '0;
                state_n    = SEARCH;
            end else begin
                phase_n   = idx;
                ref_idx_n = idx;
                ref_vld_n = 1'b1;
                if (!ref_vld) begin
                    run_n = '0;
                end else if (idx == ref_idx + 3'd1) begin
                    if (state == SEARCH) begin
                        run_n = run + 4'd1;
                        if (run_n >= 4'(LOCK_CNT))
                            state_n = LOCKED;
                    end
                end else begin
                    // The offending code still becomes the reference.
                    seq_err_n = 1'b1;
                    run_n     = '0;
                    state_n   = SEARCH;
                end
            end
            if ((code_err_n || seq_err_n) && (err_cnt != '1))
                err_cnt_n = err_cnt + ERR_W'(1);
        end

        phase_oh_n = 8'(1) << phase_n;
        locked_n   = (state_n == LOCKED);
    end

    assign bus.phase    = phase;
    assign bus.phase_oh = phase_oh;
    assign bus.code_err = code_err;
    assign bus.seq_err  = seq_err;
    assign bus.locked   = locked;
    assign bus.err_cnt  = err_cnt;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: table-driven stream on the default
// instance plus hand sequences for async reset, LOCK_CNT=1 and saturation.
module tb_johnson_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    johnson_decoder_if #(.ERR_W(8)) bus_a ();
    johnson_decoder_if #(.ERR_W(2)) bus_b ();

    johnson_decoder #(.LOCK_CNT(3), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    johnson_decoder #(.LOCK_CNT(1), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [3:0] code;
        logic       vld;
        logic [2:0] ph;
        logic       ce;
        logic       se;
        logic       lk;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] ph, input logic ce,
                         input logic se, input logic lk, input logic [7:0] ec);
        logic [7:0] oh;
        oh = 8'd1 << ph;
        chk({tag, ".phase"},    32'(bus_a.phase),    32'(ph));
        chk({tag, ".phase_oh"}, 32'(bus_a.phase_oh), 32'(oh));
        chk({tag, ".code_err"}, 32'(bus_a.code_err), 32'(ce));
        chk({tag, ".seq_err"},  32'(bus_a.seq_err),  32'(se));
        chk({tag, ".locked"},   32'(bus_a.locked),   32'(lk));
        chk({tag, ".err_cnt"},  32'(bus_a.err_cnt),  32'(ec));
    endtask

    task automatic step(input logic [3:0] ca, input logic va,
                        input logic [3:0] cb, input logic vb);
        @(negedge clk);
        bus_a.code_in = ca; bus_a.code_vld = va;
        bus_b.code_in = cb; bus_b.code_vld = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] c, input logic v, input logic [2:0] ph,
                       input logic ce, input logic se, input logic lk, input logic [7:0] ec);
        vecs.push_back('{code: c, vld: v, ph: ph, ce: ce, se: se, lk: lk, ec: ec});
    endtask

    initial begin
        bus_a.code_in = 4'b0000; bus_a.code_vld = 1'b0;
        bus_b.code_in = 4'b0000; bus_b.code_vld = 1'b0;

        // clean stream, lock after the 4th legal code
        add(4'b0000, 1, 3'd0, 0, 0, 0, 0);
        add(4'b1000, 1, 3'd1, 0, 0, 0, 0);
        add(4'b1100, 1, 3'd2, 0, 0, 0, 0);
        add(4'b1110, 1, 3'd3, 0, 0, 1, 0);
        add(4'b1111, 1, 3'd4, 0, 0, 1, 0);
        // wrap-around 7 -> 0
        add(4'b0111, 1, 3'd5, 0, 0, 1, 0);
        add(4'b0011, 1, 3'd6, 0, 0, 1, 0);
        add(4'b0001, 1, 3'd7, 0, 0, 1, 0);
        add(4'b0000, 1, 3'd0, 0, 0, 1, 0);
        add(4'b1000, 1, 3'd1, 0, 0, 1, 0);
        add(4'b1100, 1, 3'd2, 0, 0, 1, 0);
        // illegal code: phase holds, lock drops, reference cleared
        add(4'b1010, 1, 3'd2, 1, 0, 0, 1);
        add(4'b1110, 1, 3'd3, 0, 0, 0, 1);
        add(4'b1111, 1, 3'd4, 0, 0, 0, 1);
        add(4'b0111, 1, 3'd5, 0, 0, 0, 1);
        add(4'b0011, 1, 3'd6, 0, 0, 1, 1);
        add(4'b0001, 1, 3'd7, 0, 0, 1, 1);
        add(4'b0000, 1, 3'd0, 0, 0, 1, 1);
        add(4'b1000, 1, 3'd1, 0, 0, 1, 1);
        // skip, then successor, then repeat
        add(4'b1110, 1, 3'd3, 0, 1, 0, 2);
        add(4'b1111, 1, 3'd4, 0, 0, 0, 2);
        add(4'b1111, 1, 3'd4, 0, 1, 0, 3);
        // gated: illegal code ignored while code_vld is low
        for (int i = 0; i < 5; i++) add(4'b1010, 0, 3'd4, 0, 0, 0, 3);
        add(4'b0111, 1, 3'd5, 0, 0, 0, 3);
        add(4'b0011, 1, 3'd6, 0, 0, 0, 3);
        add(4'b0001, 1, 3'd7, 0, 0, 1, 3);
        add(4'b0000, 1, 3'd0, 0, 0, 1, 3);
        add(4'b1000, 1, 3'd1, 0, 0, 1, 3);
        add(4'b1100, 1, 3'd2, 0, 0, 1, 3);
        add(4'b1110, 1, 3'd3, 0, 0, 1, 3);
        add(4'b1111, 1, 3'd4, 0, 0, 1, 3);
        add(4'b0111, 1, 3'd5, 0, 0, 1, 3);

        #12;
        chk_a("reset", 3'd0, 0, 0, 0, 8'd0);
        chk("reset.b_err_cnt", 32'(bus_b.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].code, vecs[i].vld, 4'b0000, 1'b0);
            chk_a($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ce, vecs[i].se,
                  vecs[i].lk, vecs[i].ec);
        end

        // asynchronous reset while locked at phase 5
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_a("async_rst", 3'd0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        step(4'b0011, 1, 4'b0000, 0);
        chk_a("post_rst0", 3'd6, 0, 0, 0, 8'd0);
        step(4'b0001, 1, 4'b0000, 0);
        chk_a("post_rst1", 3'd7, 0, 0, 0, 8'd0);

        // LOCK_CNT=1 instance: one successor is enough to lock
        step(4'b0000, 0, 4'b0000, 1);
        chk("b.lock0", 32'(bus_b.locked), 32'd0);
        step(4'b0000, 0, 4'b1000, 1);
        chk("b.lock1", 32'(bus_b.locked), 32'd1);
        chk("b.phase1", 32'(bus_b.phase), 32'd1);

        // ERR_W=2 saturation
        begin
            logic [3:0] bad [5];
            logic [1:0] exp_ec [5];
            bad    = '{4'b1010, 4'b1011, 4'b0101, 4'b1001, 4'b0100};
            exp_ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                step(4'b0000, 0, bad[i], 1);
                chk($sformatf("sat%0d.err_cnt", i), 32'(bus_b.err_cnt), 32'(exp_ec[i]));
                chk($sformatf("sat%0d.code_err", i), 32'(bus_b.code_err), 32'd1);
                chk($sformatf("sat%0d.locked", i), 32'(bus_b.locked), 32'd0);
                chk($sformatf("sat%0d.phase", i), 32'(bus_b.phase), 32'd1);
            end
        end
        step(4'b0000, 0, 4'b1010, 0);
        chk("sat_idle.code_err", 32'(bus_b.code_err), 32'd0);
        chk("sat_idle.err_cnt", 32'(bus_b.err_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side checker for the 4-bit Johnson (twisted-ring) counter. Samples the 4-bit code produced by the ring counter, converts it to a binary phase index and a one-hot phase, and flags illegal codes and illegal steps. It also runs a lock state machine that reports when the incoming sequence is trustworthy. It sits downstream of the Johnson counter, for example across a module boundary or after a synchronizer, and feeds phase-dependent logic.

## Interface
- LOCK_CNT, default 3: number of consecutive legal successor steps needed to enter LOCKED. Range 1..15.
- ERR_W, default 8: width of the saturating error counter.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- code_in  input  4  Johnson code. Bit [3] is the leading stage; it loads the complement of bit [0].
- code_vld  input  1  code_in is sampled on this edge when high.
- phase  output  3  binary index of the last legal code.
- phase_oh  output  8  one-hot form of phase; bit i is set when phase == i.
- code_err  output  1  one-cycle pulse: the sampled code is not one of the 8 legal codes.
- seq_err  output  1  one-cycle pulse: the code is legal but is not the successor of the previous legal code.
- locked  output  1  high while the FSM is in LOCKED.
- err_cnt  output  ERR_W  count of errored samples, saturating.

## Operation
- Legal code to index mapping (code_in[3:0] → index): 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7. The other 8 codes are illegal.
- Successor rule: the next index is (prev+1) mod 8, so 0001 (index 7) is followed by 0000 (index 0). A repeated code is a seq_err; stalling is not legal.
- When code_vld=0: all registered state holds, code_err and seq_err are 0, and no checks run.
- Legal sample: phase and phase_oh update to the decoded index.
- Illegal sample:
  - code_err=1.
  - phase and phase_oh hold their previous value.
  - The reference is marked invalid.
- seq_err is evaluated only when a valid reference exists, i.e. the previous sampled code was legal. The first legal code after reset, or after an illegal code, sets the reference and produces no seq_err.
- code_err and seq_err are never asserted together.
- err_cnt increments by 1 for each sample with code_err or seq_err. It saturates at 2^ERR_W-1 and never wraps.
- FSM states, held in a run counter `run`:
  - SEARCH:
    - A legal sample with no reference sets run=0.
    - A legal successor increments run.
    - When run reaches LOCK_CNT, go to LOCKED.
    - Any error sets run=0. If the error was a seq_err, the new code becomes the reference.
  - LOCKED: a legal successor keeps LOCKED. Any code_err or seq_err goes to SEARCH with run=0; after a seq_err the erroring code becomes the new reference.
- Reset values: phase=0, phase_oh=8'b0000_0001, code_err=0, seq_err=0, locked=0, err_cnt=0, FSM=SEARCH, reference invalid, run=0.
- Reset asserted mid-stream forces all of the above immediately. The first sample after reset release is treated as having no reference.

## Timing
- Every output is a register. Latency is 1 cycle: a value sampled on edge N appears after edge N.
- code_err and seq_err stay high for exactly one cycle per offending sample.
- With code_vld held high and a clean stream starting after reset, locked rises after the edge that samples the (LOCK_CNT+1)-th legal code. With LOCK_CNT=3 that is the 4th code.
- locked falls after the same edge that raises the error pulse.
- err_cnt updates on the same edge as the error pulse.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package johnson_pkg:
  - constant JOHNSON_LEN=8;
  - the legal-code table;
  - FSM state typedef {SEARCH, LOCKED};
  - function code2idx returning {legal, idx[2:0]}.
- Natural sub-module: johnson_code2idx, a purely combinational validity check and index lookup. It can be reused by future encoder-side checkers.
- The top level holds the reference register, run counter, FSM, error counter and output registers.

## Test plan
- Clean stream: reset, then code_vld=1 with 0000,1000,1100,1110,1111 → phase 0,1,2,3,4; locked=1 after the 1110 sample; err_cnt=0.
- Wrap-around: locked stream …0011,0001,0000,1000 → phase 6,7,0,1; no errors; locked stays 1.
- Illegal code: while locked at 1100, inject 1010 → code_err pulse; phase holds 2; locked=0; err_cnt=1. Then 1110 is the new reference with no seq_err, and locked returns after 3 more successors.
- Skip/repeat: locked at 1000, then send 1110 → seq_err, err_cnt+1, locked=0. Next 1111 is accepted as a successor (run=1). Sending 1111 twice produces a seq_err on the repeat.
- Gating and saturation: code_vld=0 with an illegal code_in for 5 cycles → no pulses, outputs frozen. With ERR_W=2, 5 illegal samples → err_cnt stops at 3.
- Reset mid-stream: assert rst low while locked at phase 5 → immediately phase=0, phase_oh=00000001, locked=0, err_cnt=0. After release, the first sample 0011 gives no seq_err.
